// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the teaching-CPU control unit and its datapath:
// opcodes, FSM states, instruction field positions and the control-word layout.
package multicycle_control_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_LW  = 2'b01,
    OP_SW  = 2'b10,
    OP_JMP = 2'b11
  } opcode_t;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  // Instruction word layout: [7:6] opcode, [5:4] rs, [3:2] rt, [1:0] rd/imm.
  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 6;
  localparam int RS_MSB  = 5;
  localparam int RS_LSB  = 4;
  localparam int RT_MSB  = 3;
  localparam int RT_LSB  = 2;
  localparam int IMM_MSB = 1;
  localparam int IMM_LSB = 0;

  typedef struct packed {
    logic ir_write;
    logic pc_write;
    logic pc_src;
    logic alu_src_imm;
    logic reg_write;
    logic reg_dst_rd;
    logic mem_to_reg;
    logic mem_req;
    logic mem_we;
    logic busy;
  } ctrl_t;

  function automatic opcode_t opcode_of(input logic [7:0] instr);
    return opcode_t'(instr[OPC_MSB:OPC_LSB]);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bus between the multi-cycle controller (master) and the datapath /
// data-memory side (slave).
interface multicycle_control_if #(
  parameter int CNT_W = 8
);
  logic             run;
  logic [7:0]       instr;
  logic             mem_ready;
  logic             ir_write;
  logic             pc_write;
  logic             pc_src;
  logic             alu_src_imm;
  logic             reg_write;
  logic             reg_dst_rd;
  logic             mem_to_reg;
  logic             mem_req;
  logic             mem_we;
  logic             busy;
  logic [CNT_W-1:0] retired;

  modport master (
    input  run, instr, mem_ready,
    output ir_write, pc_write, pc_src, alu_src_imm, reg_write, reg_dst_rd,
           mem_to_reg, mem_req, mem_we, busy, retired
  );

  modport slave (
    output run, instr, mem_ready,
    input  ir_write, pc_write, pc_src, alu_src_imm, reg_write, reg_dst_rd,
           mem_to_reg, mem_req, mem_we, busy, retired
  );
endinterface

// File: rtl/multicycle_control_retire_counter.sv
// Retired-instruction counter: synchronous enable, asynchronous clear,
// wraps naturally at 2^CNT_W.
module retire_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencing for the
// 4-opcode 8-bit CPU, datapath control decode, memory handshake, retire count.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  state_t           state;
  opcode_t          ir_op;
  ctrl_t            ctrl;
  logic             fetch_go;
  logic             retire;
  logic [CNT_W-1:0] retired_count;

  // The only path from run into the outputs; instr never reaches them.
  assign fetch_go = bus.run & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
      ir_op <= OP_ADD;
    end else begin
      case (state)
        S_FETCH: begin
          if (bus.run) begin
            ir_op <= opcode_of(bus.instr);
            state <= S_DECODE;
          end
        end
        S_DECODE: state <= S_EXEC;
        S_EXEC: begin
          case (ir_op)
            OP_ADD:       state <= S_WB;
            OP_LW, OP_SW: state <= S_MEM;
            default:      state <= S_FETCH;
          endcase
        end
        S_MEM: begin
          if (bus.mem_ready) begin
            state <= (ir_op == OP_LW) ? S_WB : S_FETCH;
          end
        end
        S_WB:    state <= S_FETCH;
        default: state <= S_FETCH;
      endcase
    end
  end

  // Output decode from the registered state and IR opcode; state resets
  // asynchronously, so mem_req falls as soon as reset rises.
  always_comb begin
    // NOTE: defaulting the whole control word first keeps every path fully
    // assigned, so no latch can be inferred from a missed case arm.
    ctrl      = '0;
    ctrl.busy = 1'b1;
    case (state)
      S_FETCH: begin
        ctrl.ir_write = fetch_go;
        ctrl.pc_write = fetch_go;
        ctrl.busy     = fetch_go;
      end
      S_EXEC: begin
        case (ir_op)
          OP_LW, OP_SW: ctrl.alu_src_imm = 1'b1;
          OP_JMP: begin
            ctrl.pc_write = 1'b1;
            ctrl.pc_src   = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_we  = (ir_op == OP_SW);
      end
      S_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst_rd = (ir_op == OP_ADD);
        ctrl.mem_to_reg = (ir_op == OP_LW);
      end
      default: ;
    endcase
  end

  assign retire = (state == S_WB)
                | ((state == S_EXEC) && (ir_op == OP_JMP))
                | ((state == S_MEM) && bus.mem_ready && (ir_op == OP_SW));

  retire_counter #(.CNT_W(CNT_W)) u_retire_counter (
    .clk   (clk),
    .reset (reset),
    .en    (retire),
    .count (retired_count)
  );

  assign bus.ir_write    = ctrl.ir_write;
  assign bus.pc_write    = ctrl.pc_write;
  assign bus.pc_src      = ctrl.pc_src;
  assign bus.alu_src_imm = ctrl.alu_src_imm;
  assign bus.reg_write   = ctrl.reg_write;
  assign bus.reg_dst_rd  = ctrl.reg_dst_rd;
  assign bus.mem_to_reg  = ctrl.mem_to_reg;
  assign bus.mem_req     = ctrl.mem_req;
  assign bus.mem_we      = ctrl.mem_we;
  assign bus.busy        = ctrl.busy;
  assign bus.retired     = retired_count;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle control words for ADD, LW,
// SW and JMP, counter wrap, run gating and asynchronous reset inside MEM.
module tb_multicycle_control;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  multicycle_control_if #(.CNT_W(8)) bus ();

  multicycle_control #(.CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word order: ir_write pc_write pc_src alu_src_imm reg_write
  //                     reg_dst_rd mem_to_reg mem_req mem_we busy
  localparam logic [9:0] C_IDLE    = 10'b0000000000;
  localparam logic [9:0] C_FETCH   = 10'b1100000001;
  localparam logic [9:0] C_DECODE  = 10'b0000000001;
  localparam logic [9:0] C_EX_ADD  = 10'b0000000001;
  localparam logic [9:0] C_EX_MEM  = 10'b0001000001;
  localparam logic [9:0] C_EX_JMP  = 10'b0110000001;
  localparam logic [9:0] C_MEM_LW  = 10'b0000000101;
  localparam logic [9:0] C_MEM_SW  = 10'b0000000111;
  localparam logic [9:0] C_WB_ADD  = 10'b0000110001;
  localparam logic [9:0] C_WB_LW   = 10'b0000101001;

  localparam logic [7:0] I_ADD = 8'b00_01_10_11;
  localparam logic [7:0] I_LW  = 8'b01_00_01_11;
  localparam logic [7:0] I_SW  = 8'b10_01_10_01;
  localparam logic [7:0] I_JMP = 8'b11_00_00_10;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] ctrl_word();
    return {bus.ir_write, bus.pc_write, bus.pc_src, bus.alu_src_imm, bus.reg_write,
            bus.reg_dst_rd, bus.mem_to_reg, bus.mem_req, bus.mem_we, bus.busy};
  endfunction

  task automatic expect_ctrl(input string tag, input logic [9:0] exp);
    @(negedge clk);
    check(tag, {22'd0, ctrl_word()}, {22'd0, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    bus.run       = 1'b0;
    bus.instr     = 8'h00;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    expect_ctrl("reset_outputs", C_IDLE);
    check("reset_retired", {24'd0, bus.retired}, 32'd0);

    // ADD; instr is scrambled after FETCH to prove the IR opcode is used.
    step();
    reset     = 1'b0;
    bus.run   = 1'b1;
    bus.instr = I_ADD;
    expect_ctrl("add_fetch", C_FETCH);
    step();
    bus.instr = 8'hFF;
    expect_ctrl("add_decode", C_DECODE);
    step();
    expect_ctrl("add_exec", C_EX_ADD);
    step();
    bus.instr = I_LW;
    expect_ctrl("add_wb", C_WB_ADD);
    check("add_not_yet_retired", {24'd0, bus.retired}, 32'd0);

    // LW with two wait cycles; mem_ready pulsed in EXEC must be ignored.
    step();
    expect_ctrl("lw_fetch", C_FETCH);
    check("add_retired", {24'd0, bus.retired}, 32'd1);
    step();
    bus.instr = 8'hC0;
    expect_ctrl("lw_decode", C_DECODE);
    step();
    bus.mem_ready = 1'b1;
    expect_ctrl("lw_exec", C_EX_MEM);
    step();
    bus.mem_ready = 1'b0;
    expect_ctrl("lw_mem1", C_MEM_LW);
    step();
    expect_ctrl("lw_mem2", C_MEM_LW);
    step();
    bus.mem_ready = 1'b1;
    expect_ctrl("lw_mem3", C_MEM_LW);
    step();
    bus.mem_ready = 1'b0;
    bus.instr     = I_SW;
    expect_ctrl("lw_wb", C_WB_LW);

    // SW with zero wait cycles.
    step();
    expect_ctrl("sw_fetch", C_FETCH);
    check("lw_retired", {24'd0, bus.retired}, 32'd2);
    step();
    expect_ctrl("sw_decode", C_DECODE);
    step();
    expect_ctrl("sw_exec", C_EX_MEM);
    step();
    bus.mem_ready = 1'b1;
    bus.instr     = I_JMP;
    expect_ctrl("sw_mem", C_MEM_SW);

    // JMP, 3 cycles.
    step();
    bus.mem_ready = 1'b0;
    expect_ctrl("jmp_fetch", C_FETCH);
    check("sw_retired", {24'd0, bus.retired}, 32'd3);
    step();
    expect_ctrl("jmp_decode", C_DECODE);
    step();
    expect_ctrl("jmp_exec", C_EX_JMP);
    step();
    expect_ctrl("jmp_refetch", C_FETCH);
    check("jmp_retired", {24'd0, bus.retired}, 32'd4);

    // 251 more JMPs bring the count to 255, then one more wraps it.
    repeat (3 * 251) @(posedge clk);
    expect_ctrl("preload_fetch", C_FETCH);
    check("preload_255", {24'd0, bus.retired}, 32'd255);
    repeat (3) @(posedge clk);
    expect_ctrl("wrap_fetch", C_FETCH);
    check("wrap_to_zero", {24'd0, bus.retired}, 32'd0);

    // Drop run during DECODE of an ADD: it completes, then idles.
    bus.instr = I_ADD;
    step();
    bus.run = 1'b0;
    expect_ctrl("gate_decode", C_DECODE);
    step();
    expect_ctrl("gate_exec", C_EX_ADD);
    step();
    expect_ctrl("gate_wb", C_WB_ADD);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_ctrl($sformatf("gate_idle%0d", i), C_IDLE);
    end
    check("gate_retired", {24'd0, bus.retired}, 32'd1);
    step();
    bus.run   = 1'b1;
    bus.instr = I_LW;
    expect_ctrl("gate_resume", C_FETCH);

    // Reset asserted mid-MEM of an LW.
    step();
    expect_ctrl("rst_lw_decode", C_DECODE);
    step();
    expect_ctrl("rst_lw_exec", C_EX_MEM);
    step();
    expect_ctrl("rst_lw_mem", C_MEM_LW);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_ctrl", {22'd0, ctrl_word()}, 32'd0);
    check("rst_async_retired", {24'd0, bus.retired}, 32'd0);
    bus.instr = I_ADD;
    step();
    reset = 1'b0;
    expect_ctrl("rst_release_fetch", C_FETCH);
    check("rst_release_retired", {24'd0, bus.retired}, 32'd0);
    step();
    expect_ctrl("rst_release_decode", C_DECODE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
